// File: rtl/clock_cal_pkg.sv
// Shared types, constants and BCD helpers for the clock/calendar core.
// Contents: FSM state enum, blink_led field codes, BCD range limits,
// two-digit BCD step, leap-year test and days-in-month lookup.
package clock_cal_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_e;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_F1   = 2'b01;
    localparam logic [1:0] BLINK_F2   = 2'b10;
    localparam logic [1:0] BLINK_F3   = 2'b11;

    localparam logic [7:0]  BCD_ZERO     = 8'h00;
    localparam logic [7:0]  BCD_ONE      = 8'h01;
    localparam logic [7:0]  BCD_MAX_MS   = 8'h59;
    localparam logic [7:0]  BCD_MAX_HH   = 8'h23;
    localparam logic [7:0]  BCD_MAX_MO   = 8'h12;
    localparam logic [15:0] BCD_MAX_YYYY = 16'h9999;

    // Next value of a two-digit BCD counter; anything at or past max wraps to min.
    function automatic logic [7:0] bcd2_next(input logic [7:0] v,
                                             input logic [7:0] min_v,
                                             input logic [7:0] max_v);
        if (v >= max_v)
            return min_v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 10*t + u is divisible by 4 iff 2*t + u is, so only tens parity matters.
    function automatic logic bcd2_div4(input logic [7:0] v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else
            return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    // Century years (low pair 00) are leap only when the high pair is divisible by 4.
    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] != 8'h00)
            return bcd2_div4(y[7:0]);
        else
            return bcd2_div4(y[15:8]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0]  mo,
                                                 input logic [15:0] y,
                                                 input logic        leap_en);
        case (mo)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return (leap_en && is_leap(y)) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/clock_calendar_core_if.sv
// Button/tick inputs and display-facing outputs of the clock/calendar core.
// master: event source and display consumer; slave: the core itself.
interface clock_calendar_core_if;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_view;
    logic        btn_sel;
    logic        btn_inc;
    logic [7:0]  bcd_ss;
    logic [7:0]  bcd_mm;
    logic [7:0]  bcd_hh;
    logic [7:0]  bcd_dd;
    logic [7:0]  bcd_mo;
    logic [15:0] bcd_yyyy;
    logic        smh_dmy;
    logic        dem_chinh;
    logic [1:0]  blink_led;

    modport master (
        output tick_1hz, btn_mode, btn_view, btn_sel, btn_inc,
        input  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
        input  smh_dmy, dem_chinh, blink_led
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_view, btn_sel, btn_inc,
        output bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy,
        output smh_dmy, dem_chinh, blink_led
    );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD register with programmable wrap range.
// Ports: clk, rst (sync, active high), inc_i, load_i/load_val_i (load wins),
// min_i/max_i wrap range, val_o registered value, carry_c_o = inc at max.
module bcd2_counter
    import clock_cal_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    output logic [7:0] val_o,
    output logic       carry_c_o
);
    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load_i)
            val_d = load_val_i;
        else if (inc_i)
            val_d = bcd2_next(val_q, min_i, max_i);
    end

    always_ff @(posedge clk) begin
        if (rst)
            val_q <= RESET_VAL;
        else
            val_q <= val_d;
    end

    assign val_o     = val_q;
    assign carry_c_o = inc_i && (val_q >= max_i);
endmodule

// File: rtl/clock_calendar_core.sv
// Time/date keeping core: BCD seconds..year with Gregorian month lengths and a
// RUN/SET button state machine feeding the seven-segment display stage.
// Ports: clk, rst (sync, active high), bus (clock_calendar_core_if.slave).
// Build option: CLOCK_CAL_LEAP_EN enables leap-year February (29 days).
module clock_calendar_core
    import clock_cal_pkg::*;
#(
    parameter logic [15:0] RESET_YEAR = 16'h2000
) (
    input  logic                        clk,
    input  logic                        rst,
    clock_calendar_core_if.slave        bus
);
`ifdef CLOCK_CAL_LEAP_EN
    localparam logic LEAP_EN = 1'b1;
`else
    localparam logic LEAP_EN = 1'b0;
`endif

    state_e     state_q;
    logic       view_q;
    logic       dem_q;
    logic [1:0] blink_q;

    logic [7:0] ss_q, mm_q, hh_q, dd_q, mo_q, yl_q, yh_q;
    logic       ss_cy, mm_cy, hh_cy, dd_cy, mo_cy, yl_cy, unused_yh_cy;
    logic       run_c, set_inc_c;
    logic [2:0] fsel_c;
    logic       ss_inc_c, mm_inc_c, hh_inc_c, dd_inc_c, mo_inc_c, yl_inc_c;
    logic [7:0] mo_nxt_c, yl_nxt_c, yh_nxt_c, dim_c, dim_nxt_c;
    logic       dd_load_c;

    // Edits are suppressed when btn_mode leaves SET in the same cycle.
    assign run_c     = (state_q == ST_RUN);
    assign set_inc_c = (state_q == ST_SET) && bus.btn_inc && !bus.btn_mode;
    assign fsel_c    = {view_q, blink_q};

    // Carries only ripple in RUN; in SET a single field steps on its own.
    assign ss_inc_c = (run_c && bus.tick_1hz) || (set_inc_c && fsel_c == {1'b0, BLINK_F3});
    assign mm_inc_c = (run_c && ss_cy)        || (set_inc_c && fsel_c == {1'b0, BLINK_F2});
    assign hh_inc_c = (run_c && mm_cy)        || (set_inc_c && fsel_c == {1'b0, BLINK_F1});
    assign dd_inc_c = (run_c && hh_cy)        || (set_inc_c && fsel_c == {1'b1, BLINK_F1});
    assign mo_inc_c = (run_c && dd_cy)        || (set_inc_c && fsel_c == {1'b1, BLINK_F2});
    assign yl_inc_c = (run_c && mo_cy)        || (set_inc_c && fsel_c == {1'b1, BLINK_F3});

    // Month/year next values drive the same-cycle day clamp.
    assign mo_nxt_c  = mo_inc_c ? bcd2_next(mo_q, BCD_ONE, BCD_MAX_MO) : mo_q;
    assign yl_nxt_c  = yl_inc_c ? bcd2_next(yl_q, BCD_ZERO, BCD_MAX_YYYY[7:0]) : yl_q;
    assign yh_nxt_c  = yl_cy ? bcd2_next(yh_q, BCD_ZERO, BCD_MAX_YYYY[15:8]) : yh_q;
    assign dim_c     = days_in_month(mo_q, {yh_q, yl_q}, LEAP_EN);
    assign dim_nxt_c = days_in_month(mo_nxt_c, {yh_nxt_c, yl_nxt_c}, LEAP_EN);
    assign dd_load_c = !dd_inc_c && (dd_q > dim_nxt_c);

    bcd2_counter #(.RESET_VAL(BCD_ZERO)) u_ss (
        .clk(clk), .rst(rst), .inc_i(ss_inc_c), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ZERO), .max_i(BCD_MAX_MS), .val_o(ss_q), .carry_c_o(ss_cy));

    bcd2_counter #(.RESET_VAL(BCD_ZERO)) u_mm (
        .clk(clk), .rst(rst), .inc_i(mm_inc_c), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ZERO), .max_i(BCD_MAX_MS), .val_o(mm_q), .carry_c_o(mm_cy));

    bcd2_counter #(.RESET_VAL(BCD_ZERO)) u_hh (
        .clk(clk), .rst(rst), .inc_i(hh_inc_c), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ZERO), .max_i(BCD_MAX_HH), .val_o(hh_q), .carry_c_o(hh_cy));

    bcd2_counter #(.RESET_VAL(BCD_ONE)) u_dd (
        .clk(clk), .rst(rst), .inc_i(dd_inc_c), .load_i(dd_load_c), .load_val_i(dim_nxt_c),
        .min_i(BCD_ONE), .max_i(dim_c), .val_o(dd_q), .carry_c_o(dd_cy));

    bcd2_counter #(.RESET_VAL(BCD_ONE)) u_mo (
        .clk(clk), .rst(rst), .inc_i(mo_inc_c), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ONE), .max_i(BCD_MAX_MO), .val_o(mo_q), .carry_c_o(mo_cy));

    bcd2_counter #(.RESET_VAL(RESET_YEAR[7:0])) u_yl (
        .clk(clk), .rst(rst), .inc_i(yl_inc_c), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ZERO), .max_i(BCD_MAX_YYYY[7:0]), .val_o(yl_q), .carry_c_o(yl_cy));

    bcd2_counter #(.RESET_VAL(RESET_YEAR[15:8])) u_yh (
        .clk(clk), .rst(rst), .inc_i(yl_cy), .load_i(1'b0), .load_val_i(BCD_ZERO),
        .min_i(BCD_ZERO), .max_i(BCD_MAX_YYYY[15:8]), .val_o(yh_q), .carry_c_o(unused_yh_cy));

    // RUN/SET machine with view toggle and field selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            dem_q   <= 1'b0;
            view_q  <= 1'b0;
            blink_q <= BLINK_NONE;
        end else begin
            if (bus.btn_view)
                view_q <= !view_q;
            case (state_q)
                ST_RUN: begin
                    if (bus.btn_mode) begin
                        state_q <= ST_SET;
                        dem_q   <= 1'b1;
                        blink_q <= BLINK_F1;
                    end
                end
                ST_SET: begin
                    if (bus.btn_mode) begin
                        state_q <= ST_RUN;
                        dem_q   <= 1'b0;
                        blink_q <= BLINK_NONE;
                    end else if (bus.btn_sel) begin
                        blink_q <= (blink_q == BLINK_F3) ? BLINK_F1 : blink_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    dem_q   <= 1'b0;
                    blink_q <= BLINK_NONE;
                end
            endcase
        end
    end

    assign bus.bcd_ss    = ss_q;
    assign bus.bcd_mm    = mm_q;
    assign bus.bcd_hh    = hh_q;
    assign bus.bcd_dd    = dd_q;
    assign bus.bcd_mo    = mo_q;
    assign bus.bcd_yyyy  = {yh_q, yl_q};
    assign bus.smh_dmy   = view_q;
    assign bus.dem_chinh = dem_q;
    assign bus.blink_led = blink_q;
endmodule

// File: tb/tb_clock_calendar_core.sv
// Self-checking bench for clock_calendar_core: a vector table of single-cycle
// events plus hand-built presets for rollover, leap-year and clamp cases.
module tb_clock_calendar_core;
`ifdef CLOCK_CAL_LEAP_EN
    localparam logic LEAP = 1'b1;
`else
    localparam logic LEAP = 1'b0;
`endif

    localparam logic [5:0] EV_NONE = 6'b000000;
    localparam logic [5:0] EV_RST  = 6'b100000;
    localparam logic [5:0] EV_TICK = 6'b010000;
    localparam logic [5:0] EV_MODE = 6'b001000;
    localparam logic [5:0] EV_VIEW = 6'b000100;
    localparam logic [5:0] EV_SEL  = 6'b000010;
    localparam logic [5:0] EV_INC  = 6'b000001;

    typedef struct packed {
        logic [7:0]  hh;
        logic [7:0]  mm;
        logic [7:0]  ss;
        logic [7:0]  dd;
        logic [7:0]  mo;
        logic [15:0] yyyy;
        logic        view;
        logic        dem;
        logic [1:0]  blink;
    } obs_t;

    typedef struct {
        logic [5:0] ev;
        obs_t       exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    obs_t sb_q[$];
    vec_t vecs[18];

    clock_calendar_core_if intf ();

    clock_calendar_core #(.RESET_YEAR(16'h2000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = !clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    function automatic obs_t mk(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                                input logic [7:0] dd, input logic [7:0] mo, input logic [15:0] yyyy,
                                input logic view, input logic dem, input logic [1:0] blink);
        obs_t o;
        o.hh = hh; o.mm = mm; o.ss = ss; o.dd = dd; o.mo = mo; o.yyyy = yyyy;
        o.view = view; o.dem = dem; o.blink = blink;
        return o;
    endfunction

    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic obs_t observe();
        return mk(intf.bcd_hh, intf.bcd_mm, intf.bcd_ss, intf.bcd_dd, intf.bcd_mo,
                  intf.bcd_yyyy, intf.smh_dmy, intf.dem_chinh, intf.blink_led);
    endfunction

    // One-cycle event: driven after a falling edge, released just after the rising edge.
    task automatic drive(input logic [5:0] ev);
        @(negedge clk);
        rst           = ev[5];
        intf.tick_1hz = ev[4];
        intf.btn_mode = ev[3];
        intf.btn_view = ev[2];
        intf.btn_sel  = ev[1];
        intf.btn_inc  = ev[0];
        @(posedge clk);
        #1;
        rst           = 1'b0;
        intf.tick_1hz = 1'b0;
        intf.btn_mode = 1'b0;
        intf.btn_view = 1'b0;
        intf.btn_sel  = 1'b0;
        intf.btn_inc  = 1'b0;
    endtask

    task automatic check_pop(input string name);
        obs_t e;
        obs_t a;
        e = sb_q.pop_front();
        a = observe();
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h:%h:%h %h/%h/%h view=%b set=%b blink=%b, expected %h:%h:%h %h/%h/%h view=%b set=%b blink=%b",
                     name, a.hh, a.mm, a.ss, a.dd, a.mo, a.yyyy, a.view, a.dem, a.blink,
                     e.hh, e.mm, e.ss, e.dd, e.mo, e.yyyy, e.view, e.dem, e.blink);
        end
    endtask

    task automatic step(input logic [5:0] ev, input obs_t exp, input string name);
        sb_q.push_back(exp);
        drive(ev);
        check_pop(name);
    endtask

    // Reset, then dial every field in through SET; ends in RUN, time view.
    task automatic preset(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                          input logic [7:0] dd, input logic [7:0] mo, input logic [15:0] yyyy);
        drive(EV_RST);
        drive(EV_MODE);
        repeat (b2i(hh)) drive(EV_INC);
        drive(EV_SEL);
        repeat (b2i(mm)) drive(EV_INC);
        drive(EV_SEL);
        repeat (b2i(ss)) drive(EV_INC);
        drive(EV_VIEW);
        repeat ((b2i(yyyy[15:8]) * 100 + b2i(yyyy[7:0]) + 8000) % 10000) drive(EV_INC);
        drive(EV_SEL);
        drive(EV_SEL);
        repeat (b2i(mo) - 1) drive(EV_INC);
        drive(EV_SEL);
        drive(EV_SEL);
        repeat (b2i(dd) - 1) drive(EV_INC);
        drive(EV_VIEW);
        step(EV_MODE, mk(hh, mm, ss, dd, mo, yyyy, 1'b0, 1'b0, 2'b00), "preset");
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst           = 1'b1;
        intf.tick_1hz = 1'b0;
        intf.btn_mode = 1'b0;
        intf.btn_view = 1'b0;
        intf.btn_sel  = 1'b0;
        intf.btn_inc  = 1'b0;

        vecs[0]  = '{EV_RST,                   mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "reset"};
        vecs[1]  = '{EV_TICK,                  mk(8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "tick"};
        vecs[2]  = '{EV_TICK | EV_SEL | EV_INC, mk(8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "run_ignores_sel_inc"};
        vecs[3]  = '{EV_VIEW,                  mk(8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 16'h2000, 1'b1, 1'b0, 2'b00), "view_date"};
        vecs[4]  = '{EV_VIEW,                  mk(8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "view_time"};
        vecs[5]  = '{EV_TICK | EV_MODE,        mk(8'h00, 8'h00, 8'h03, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "tick_and_mode"};
        vecs[6]  = '{EV_TICK,                  mk(8'h00, 8'h00, 8'h03, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "tick_frozen_in_set"};
        vecs[7]  = '{EV_INC,                   mk(8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "inc_hh"};
        vecs[8]  = '{EV_SEL,                   mk(8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b10), "sel_mm"};
        vecs[9]  = '{EV_INC | EV_SEL,          mk(8'h01, 8'h01, 8'h03, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b11), "inc_then_sel"};
        vecs[10] = '{EV_INC,                   mk(8'h01, 8'h01, 8'h04, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b11), "inc_ss"};
        vecs[11] = '{EV_SEL,                   mk(8'h01, 8'h01, 8'h04, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "sel_wrap"};
        vecs[12] = '{EV_VIEW,                  mk(8'h01, 8'h01, 8'h04, 8'h01, 8'h01, 16'h2000, 1'b1, 1'b1, 2'b01), "view_in_set"};
        vecs[13] = '{EV_INC | EV_VIEW,         mk(8'h01, 8'h01, 8'h04, 8'h02, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "inc_dd_then_view"};
        vecs[14] = '{EV_MODE | EV_INC,         mk(8'h01, 8'h01, 8'h04, 8'h02, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "mode_wins_inc"};
        vecs[15] = '{EV_TICK,                  mk(8'h01, 8'h01, 8'h05, 8'h02, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "tick_resumes"};
        vecs[16] = '{EV_MODE,                  mk(8'h01, 8'h01, 8'h05, 8'h02, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "enter_set"};
        vecs[17] = '{EV_RST,                   mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "reset_in_set"};

        for (int i = 0; i < 18; i++)
            step(vecs[i].ev, vecs[i].exp, vecs[i].name);

        // One hour of ticks from reset.
        drive(EV_RST);
        repeat (3600) drive(EV_TICK);
        step(EV_NONE, mk(8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b0, 2'b00), "hour_of_ticks");

        // Full carry chain through the year wrap.
        preset(8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 16'h9999);
        step(EV_TICK, mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h0000, 1'b0, 1'b0, 2'b00), "millennium_wrap");

        // February end in leap, century and 400-year cases.
        preset(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 16'h2024);
        step(EV_TICK, LEAP ? mk(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h2024, 1'b0, 1'b0, 2'b00)
                           : mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 16'h2024, 1'b0, 1'b0, 2'b00), "feb_2024");
        preset(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 16'h2100);
        step(EV_TICK, mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 16'h2100, 1'b0, 1'b0, 2'b00), "feb_2100");
        preset(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 16'h2000);
        step(EV_TICK, LEAP ? mk(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 16'h2000, 1'b0, 1'b0, 2'b00)
                           : mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 16'h2000, 1'b0, 1'b0, 2'b00), "feb_2000");

        // Day clamp when the month shortens in SET; ticks stay frozen.
        preset(8'h00, 8'h00, 8'h00, 8'h31, 8'h03, 16'h2000);
        step(EV_MODE, mk(8'h00, 8'h00, 8'h00, 8'h31, 8'h03, 16'h2000, 1'b0, 1'b1, 2'b01), "clamp_enter");
        step(EV_VIEW, mk(8'h00, 8'h00, 8'h00, 8'h31, 8'h03, 16'h2000, 1'b1, 1'b1, 2'b01), "clamp_view");
        step(EV_SEL,  mk(8'h00, 8'h00, 8'h00, 8'h31, 8'h03, 16'h2000, 1'b1, 1'b1, 2'b10), "clamp_sel_mo");
        step(EV_INC,  mk(8'h00, 8'h00, 8'h00, 8'h30, 8'h04, 16'h2000, 1'b1, 1'b1, 2'b10), "clamp_dd");
        step(EV_TICK, mk(8'h00, 8'h00, 8'h00, 8'h30, 8'h04, 16'h2000, 1'b1, 1'b1, 2'b10), "clamp_tick_frozen");

        // Seconds wrap in SET does not carry into minutes; selection cycles back.
        preset(8'h00, 8'h05, 8'h59, 8'h01, 8'h01, 16'h2000);
        step(EV_MODE, mk(8'h00, 8'h05, 8'h59, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "ss_enter");
        step(EV_SEL,  mk(8'h00, 8'h05, 8'h59, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b10), "ss_sel1");
        step(EV_SEL,  mk(8'h00, 8'h05, 8'h59, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b11), "ss_sel2");
        step(EV_INC,  mk(8'h00, 8'h05, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b11), "ss_wrap_no_carry");
        step(EV_SEL,  mk(8'h00, 8'h05, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b0, 1'b1, 2'b01), "ss_sel3");
        step(EV_VIEW, mk(8'h00, 8'h05, 8'h00, 8'h01, 8'h01, 16'h2000, 1'b1, 1'b1, 2'b01), "ss_view_keeps_blink");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
